// File: rtl/i2c_master_arbiter_pkg.sv
// Shared definitions for the I2C master arbiter: bus field widths, FSM state
// encoding and the index-width helper used by the arbiter and its selector.
package i2c_master_arbiter_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_BUSY     = 3'd2,
    ST_COMPLETE = 3'd3,
    ST_ABORT    = 3'd4
  } state_t;

  // Width of a binary requester index; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_master_arbiter_rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   req        per-requester request levels
//   ptr        highest-priority requester index for this decision
//   grant_c    one-hot select of the first set req bit at or above ptr (wrapping)
//   idx_c      binary index of that bit
//   any_req_c  high when any req bit is set
module i2c_master_arbiter_rr_arbiter
  import i2c_master_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   idx_c,
  output logic               any_req_c
);

  int unsigned        pos;
  logic [IDX_W-1:0]   pos_idx;

  // Walk NUM_REQ slots starting at ptr; the first set bit wins.
  always_comb begin
    grant_c   = '0;
    idx_c     = '0;
    any_req_c = 1'b0;
    pos       = 0;
    pos_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos     = (32'(ptr) + i) % NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (!any_req_c && req[pos_idx]) begin
        any_req_c        = 1'b1;
        grant_c[pos_idx] = 1'b1;
        idx_c            = pos_idx;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master write engine among NUM_REQ requesters using
// round-robin arbitration, with per-requester completion/timeout pulses.
// Ports:
//   clk, reset                 system clock, async active-high reset
//   req/req_addr/req_data      per-requester request level, 7b address, 8b data (flattened)
//   grant                      one-hot, held for the whole transaction
//   req_done/req_err           one-cycle pulse on the granted bit at completion/timeout
//   m_start/m_slave_addr/m_data_in  command to the I2C master (latched copies)
//   m_done                     completion from the I2C master (level or pulse)
//   m_abort                    one-cycle pulse, ORed externally into the master's reset
//   busy                       high whenever the FSM is not idle
module i2c_master_arbiter
  import i2c_master_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 13
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*I2C_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_err,
  output logic                          m_start,
  output logic [I2C_ADDR_W-1:0]         m_slave_addr,
  output logic [I2C_DATA_W-1:0]         m_data_in,
  input  logic                          m_done,
  output logic                          m_abort,
  output logic                          busy
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   sel;
  logic [CNT_W-1:0]   cnt;
  logic               m_done_q;

  logic [NUM_REQ-1:0] arb_grant_c;
  logic [IDX_W-1:0]   arb_idx_c;
  logic               arb_any_c;
  logic               done_edge_c;
  logic [IDX_W-1:0]   next_ptr_c;

  i2c_master_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (req),
    .ptr       (rr_ptr),
    .grant_c   (arb_grant_c),
    .idx_c     (arb_idx_c),
    .any_req_c (arb_any_c)
  );

  // Edge detect lets both level-done and pulse-done masters work; the
  // edge register tracks m_done in every state so a stale level is ignored.
  assign done_edge_c = m_done & ~m_done_q;

  // Pointer moves to the requester just after the one served.
  assign next_ptr_c = (32'(sel) == NUM_REQ - 1) ? '0 : sel + IDX_W'(1);

  // Transaction FSM; pulse outputs default low every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      sel          <= '0;
      cnt          <= '0;
      m_done_q     <= 1'b0;
      grant        <= '0;
      req_done     <= '0;
      req_err      <= '0;
      m_start      <= 1'b0;
      m_slave_addr <= '0;
      m_data_in    <= '0;
      m_abort      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      m_done_q <= m_done;
      m_start  <= 1'b0;
      req_done <= '0;
      req_err  <= '0;
      m_abort  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (arb_any_c) begin
            grant        <= arb_grant_c;
            sel          <= arb_idx_c;
            m_slave_addr <= req_addr[32'(arb_idx_c) * I2C_ADDR_W +: I2C_ADDR_W];
            m_data_in    <= req_data[32'(arb_idx_c) * I2C_DATA_W +: I2C_DATA_W];
            m_start      <= 1'b1;
            busy         <= 1'b1;
            state        <= ST_START;
          end
        end
        ST_START: begin
          cnt   <= '0;
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          // Done takes priority over a coincident timeout.
          if (done_edge_c) begin
            req_done <= grant;
            state    <= ST_COMPLETE;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            req_err <= grant;
            m_abort <= 1'b1;
            state   <= ST_ABORT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_COMPLETE, ST_ABORT: begin
          grant  <= '0;
          busy   <= 1'b0;
          rr_ptr <= next_ptr_c;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter: directed scenarios followed by
// randomized transactions, checked against a behavioural round-robin model.
module tb_i2c_master_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;
  localparam int CW  = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*7-1:0]   req_addr;
  logic [N*8-1:0]   req_data;
  logic [N-1:0]     grant;
  logic [N-1:0]     req_done;
  logic [N-1:0]     req_err;
  logic             m_start;
  logic [6:0]       m_slave_addr;
  logic [7:0]       m_data_in;
  logic             m_done;
  logic             m_abort;
  logic             busy;

  logic [6:0]       addr_arr [N];
  logic [7:0]       data_arr [N];

  int n_cmp = 0;
  int n_err = 0;
  int model_ptr = 0;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[7*i +: 7] = addr_arr[i];
      req_data[8*i +: 8] = data_arr[i];
    end
  end

  i2c_master_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .grant        (grant),
    .req_done     (req_done),
    .req_err      (req_err),
    .m_start      (m_start),
    .m_slave_addr (m_slave_addr),
    .m_data_in    (m_data_in),
    .m_done       (m_done),
    .m_abort      (m_abort),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference arbitration: first requester at or after ptr, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"},   32'(grant),    32'(0));
    chk({tag, "_busy"},    32'(busy),     32'(0));
    chk({tag, "_m_start"}, 32'(m_start),  32'(0));
    chk({tag, "_done"},    32'(req_done), 32'(0));
    chk({tag, "_err"},     32'(req_err),  32'(0));
    chk({tag, "_abort"},   32'(m_abort),  32'(0));
  endtask

  // One full transaction starting from an idle DUT at a falling edge.
  task automatic do_txn(input int delay, input bit pulse, input bit tmo,
                        input logic [N-1:0] set_m, input bit drop);
    int           sel;
    logic [N-1:0] oh;
    if (req == '0) req = N'(1);
    sel = pick(req, model_ptr);
    oh  = N'(1) << sel;
    @(negedge clk);
    chk("grant",      32'(grant),        32'(oh));
    chk("m_start_hi", 32'(m_start),      32'(1));
    chk("busy_hi",    32'(busy),         32'(1));
    chk("addr",       32'(m_slave_addr), 32'(addr_arr[sel]));
    chk("data",       32'(m_data_in),    32'(data_arr[sel]));
    req = (req | set_m) & ~(drop ? oh : N'(0));
    @(negedge clk);
    chk("m_start_lo", 32'(m_start), 32'(0));
    chk("grant_held", 32'(grant),   32'(oh));
    if (tmo) begin
      for (int i = 0; i < TMO; i++) begin
        chk("err_early", 32'(req_err),  32'(0));
        chk("done_tmo",  32'(req_done), 32'(0));
        @(negedge clk);
      end
      chk("req_err",     32'(req_err),  32'(oh));
      chk("m_abort",     32'(m_abort),  32'(1));
      chk("done_on_err", 32'(req_done), 32'(0));
    end else begin
      if (m_done) begin
        for (int i = 0; i < 2; i++) begin
          chk("stale_done", 32'(req_done), 32'(0));
          @(negedge clk);
        end
        m_done = 1'b0;
        chk("stale_done", 32'(req_done), 32'(0));
        @(negedge clk);
      end
      for (int i = 0; i < delay; i++) begin
        chk("done_early", 32'(req_done), 32'(0));
        chk("err_early",  32'(req_err),  32'(0));
        @(negedge clk);
      end
      m_done = 1'b1;
      @(negedge clk);
      if (pulse) m_done = 1'b0;
      chk("req_done",      32'(req_done), 32'(oh));
      chk("err_on_done",   32'(req_err),  32'(0));
      chk("abort_on_done", 32'(m_abort),  32'(0));
    end
    @(negedge clk);
    chk_idle_outputs("post_txn");
    model_ptr = (sel + 1) % N;
  endtask

  task automatic apply_reset();
    reset  = 1'b1;
    req    = '0;
    m_done = 1'b0;
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    model_ptr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    req    = '0;
    m_done = 1'b0;
    for (int k = 0; k < N; k++) begin
      addr_arr[k] = '0;
      data_arr[k] = '0;
    end
    #1;
    chk_idle_outputs("reset");
    chk("reset_addr", 32'(m_slave_addr), 32'(0));
    chk("reset_data", 32'(m_data_in),    32'(0));
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    model_ptr = 0;

    // Single request
    addr_arr[0] = 7'h50;
    data_arr[0] = 8'hA5;
    req = 4'b0001;
    do_txn(2, 1'b1, 1'b0, '0, 1'b0);
    req = '0;

    // Contention after reset: 0,1,2,3,0
    apply_reset();
    for (int k = 0; k < N; k++) begin
      addr_arr[k] = 7'(8'h50 + k);
      data_arr[k] = 8'(8'hA0 + k);
    end
    req = 4'b1111;
    repeat (5) do_txn(1, 1'b1, 1'b0, '0, 1'b0);
    req = '0;

    // Fairness: req0 held, req2 joins mid-transaction
    req = 4'b0001;
    do_txn(3, 1'b1, 1'b0, 4'b0100, 1'b0);
    do_txn(1, 1'b1, 1'b0, '0, 1'b0);
    do_txn(0, 1'b1, 1'b0, '0, 1'b0);
    req = '0;

    // Timeout then next requester served
    req = 4'b0011;
    do_txn(0, 1'b1, 1'b1, '0, 1'b0);
    do_txn(1, 1'b1, 1'b0, '0, 1'b0);
    req = '0;

    // Stale done level carried into the next transaction
    req = 4'b0100;
    do_txn(1, 1'b0, 1'b0, '0, 1'b0);
    req = 4'b1000;
    do_txn(2, 1'b1, 1'b0, '0, 1'b0);
    req = '0;

    // Reset mid-BUSY with a non-zero pointer beforehand
    req = 4'b0010;
    do_txn(1, 1'b1, 1'b0, '0, 1'b0);
    req = 4'b0100;
    @(negedge clk);
    chk("pre_rst_grant", 32'(grant), 32'(4'b0100));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk_idle_outputs("async_rst");
    model_ptr = 0;
    req       = '0;
    m_done    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b1010;
    do_txn(1, 1'b1, 1'b0, '0, 1'b0);
    req = '0;

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < N; k++) begin
        addr_arr[k] = 7'($urandom);
        data_arr[k] = 8'($urandom);
      end
      req = N'($urandom);
      if (req == '0) req[$urandom_range(N-1, 0)] = 1'b1;
      do_txn(int'($urandom_range(5, 0)), 1'($urandom_range(1, 0)),
             ($urandom_range(5, 0) == 0), N'($urandom), ($urandom_range(3, 0) == 0));
    end
    req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
Shares one I2C_Master write engine among NUM_REQ independent requesters. Round-robin arbitration picks one requester and latches its 7-bit slave address and data byte. The block pulses the master's start input, waits for the master's done, and returns a per-requester completion or timeout-error pulse. It sits between system-level agents and the single I2C_Master instance that drives scl/sda.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 4096, max clk cycles in BUSY before abort
CNT_W, 13, timeout counter width, must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester request level
req_addr  input  NUM_REQ*7  flattened slave addresses; requester i at [7i+6:7i]
req_data  input  NUM_REQ*8  flattened data bytes; requester i at [8i+7:8i]
grant  output  NUM_REQ  one-hot, held for the whole transaction
req_done  output  NUM_REQ  one-cycle pulse on the granted bit at completion
req_err  output  NUM_REQ  one-cycle pulse on the granted bit at timeout
m_start  output  1  to I2C_Master start; one-cycle pulse
m_slave_addr  output  7  to I2C_Master slave_addr; latched copy
m_data_in  output  8  to I2C_Master data_in; latched copy
m_done  input  1  from I2C_Master done
m_abort  output  1  one-cycle pulse; ORed externally into the master's reset
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, rr pointer=0, all outputs 0, latches 0, timeout counter 0, m_done edge register 0.
- All outputs are registered.
- FSM states: IDLE, START, BUSY, COMPLETE, ABORT.
- IDLE: if any req bit is high, select the first set bit searching from rr pointer upward with wrap.
  - On that edge: grant=onehot(sel), latch address and data of sel, go START.
  - Latency: req sampled at edge N gives grant high after edge N.
- START: m_start=1 for exactly this one cycle; clear timeout counter; go BUSY.
- BUSY: m_done is detected by rising edge (m_done & ~m_done_q), so both level-done and pulse-done masters work.
  - On edge detect: go COMPLETE.
  - Otherwise increment the counter. When counter==TIMEOUT_CYCLES-1, go ABORT.
- COMPLETE: req_done[sel]=1 for one cycle; grant cleared on exit; rr pointer=(sel+1) mod NUM_REQ; go IDLE.
- ABORT: req_err[sel]=1 and m_abort=1 for one cycle; grant cleared; rr pointer=(sel+1) mod NUM_REQ; go IDLE.
- Minimum transaction: 4 cycles (IDLE, START, BUSY, COMPLETE) plus master time. The next grant is issued no earlier than the cycle after COMPLETE or ABORT.
- Requester contract: hold req, addr and data stable until req_done or req_err.
  - If req drops mid-transaction, the transaction still completes on latched values and req_done still pulses.
- req changes on non-granted bits have no effect until IDLE.
- m_done high while in IDLE, START or COMPLETE is ignored. The edge register still tracks it, so a stale level cannot cause a false edge in BUSY.
- Simultaneous m_done edge and timeout in the same cycle: done wins, no error.
- Fairness: a continuously requesting agent cannot be granted twice in a row while another req is pending.
- Reset mid-transaction: everything returns to reset values immediately; no done/err pulse is generated. The master is reset by the same system reset.

Decomposition:
- Shared header i2c_defs.vh holds:
  - I2C_ADDR_W=7 and I2C_DATA_W=8
  - FSM state localparams (3-bit encoding)
- One natural sub-module, rr_arbiter: combinational round-robin select over NUM_REQ bits.
  - Inputs: req, pointer. Outputs: one-hot grant, binary index, any_req.
  - Instantiated inside i2c_master_arbiter. Pointer register and FSM stay in the parent.

Test Plan:
- Single request: req=4'b0001, addr0=7'h50, data0=8'hA5 -> grant=0001; m_slave_addr=7'h50, m_data_in=8'hA5; one m_start pulse; req_done[0] pulses once one cycle after the m_done rise; busy low afterwards.
- Contention after reset: req=4'b1111 held, each done answered -> grant order 0001,0010,0100,1000,0001; each m_start carries that requester's addr/data (addr_i=7'h50+i, data_i=8'hA0+i).
- Fairness: req0 held continuously plus req2 asserted mid-transaction -> grant sequence 0001,0100,0001; never 0001 twice while req2 is pending.
- Timeout: TIMEOUT_CYCLES=16, m_done tied 0 -> exactly 16 BUSY cycles, then one-cycle req_err[sel] and m_abort; no req_done; the next requester is granted afterwards.
- Stale done: m_done held high from a prior transaction into a new START -> no premature completion; completion occurs only on the next low-to-high m_done transition.
- Reset mid-BUSY: assert reset asynchronously between clock edges -> grant, busy, m_start, req_done, req_err all 0 immediately; after release, req=4'b0010 gets grant=0010 (pointer back to 0).
